// File: rtl/escalonador_aste_pkg.sv
// Package for the asteroid scheduler: entry field layout, direction encodings,
// the empty-slot marker and the scheduler state type.
// Entry layout (default COORD_W = 4): {x[9:6], y[5:2], dir[1:0]}.
package escalonador_aste_pkg;

   localparam int unsigned COORD_W_DEF = 4;
   localparam int unsigned DIR_W       = 2;
   localparam int unsigned DATA_W_DEF  = 2 * COORD_W_DEF + DIR_W;

   // Direction field always sits at the bottom of the entry.
   localparam int unsigned DIR_MSB = DIR_W - 1;
   localparam int unsigned DIR_LSB = 0;

   localparam logic [DIR_W-1:0] DIR_XP = 2'b00;
   localparam logic [DIR_W-1:0] DIR_XN = 2'b01;
   localparam logic [DIR_W-1:0] DIR_YP = 2'b10;
   localparam logic [DIR_W-1:0] DIR_YN = 2'b11;

   localparam logic [DATA_W_DEF-1:0] ASTE_EMPTY = 10'h000;

   typedef enum logic [2:0] {
      StIdle,
      StMvAddr,
      StMvUpd,
      StSpAddr,
      StSpChk,
      StRdAddr,
      StRdCap,
      StRdAck
   } state_e;

endpackage

// File: rtl/escalonador_aste_step.sv
// One movement step for a single asteroid entry (purely combinational).
// Configuration macro: ASTE_WRAP_EN -- when defined, coordinates wrap around the
// field and escape_o never asserts; otherwise an asteroid leaving the field is
// replaced by the empty entry and escape_o asserts.
// Ports:
//   entry_i   current entry {x, y, dir}
//   entry_o   entry after one step (dir unchanged)
//   escape_o  asteroid left the field on this step
module escalonador_aste_step
   import escalonador_aste_pkg::*;
#(
   parameter int unsigned  COORD_W = COORD_W_DEF,
   localparam int unsigned DATA_W  = 2 * COORD_W + DIR_W
) (
   input  logic [DATA_W-1:0] entry_i,
   output logic [DATA_W-1:0] entry_o,
   output logic              escape_o
);

   logic [COORD_W-1:0] x, y, x_n, y_n;
   logic [DIR_W-1:0]   dir;
   logic               edge_hit;

   assign x   = entry_i[DATA_W-1 -: COORD_W];
   assign y   = entry_i[DIR_W +: COORD_W];
   assign dir = entry_i[DIR_MSB:DIR_LSB];

   always_comb begin
      x_n      = x;
      y_n      = y;
      edge_hit = 1'b0;
      unique case (dir)
         DIR_XP: begin
            x_n      = x + COORD_W'(1);
            edge_hit = (x == '1);
         end
         DIR_XN: begin
            x_n      = x - COORD_W'(1);
            edge_hit = (x == '0);
         end
         DIR_YP: begin
            y_n      = y + COORD_W'(1);
            edge_hit = (y == '1);
         end
         default: begin
            y_n      = y - COORD_W'(1);
            edge_hit = (y == '0);
         end
      endcase
   end

`ifdef ASTE_WRAP_EN
   // Unsigned overflow of the coordinate already gives the wrapped position.
   assign entry_o  = {x_n, y_n, dir};
   assign escape_o = 1'b0;
`else
   assign entry_o  = edge_hit ? '0 : {x_n, y_n, dir};
   assign escape_o = edge_hit;
`endif

endmodule

// File: rtl/escalonador_aste.sv
// Asteroid table scheduler: sole owner of the single-port asteroid memory
// (registered address, read data valid the cycle after the address). Arbitrates
// the periodic move pass (tick), the spawner and the reader, non-preemptively,
// with priority move > spawn > read. Configuration macro: ASTE_WRAP_EN (see
// escalonador_aste_step).
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   tick_i                         request one move pass
//   mov_busy_o / mov_done_o        pass in progress / pass complete pulse
//   tick_overrun_o                 tick arrived while one was already pending
//   aste_escape_o                  asteroid left the field (cycle of the write)
//   spawn_req_i / spawn_data_i     spawn request (level) and entry to insert
//   spawn_ack_o / spawn_full_o / spawn_slot_o   spawn result
//   rd_req_i / rd_addr_i           read request (level) and slot
//   rd_ack_o / rd_data_o           read result
//   mem_we_o / mem_addr_o / mem_data_o / mem_q_i   memory port
module escalonador_aste
   import escalonador_aste_pkg::*;
#(
   parameter int unsigned  ADDR_W  = 4,
   parameter int unsigned  COORD_W = COORD_W_DEF,
   localparam int unsigned DATA_W  = 2 * COORD_W + DIR_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              tick_i,
   output logic              mov_busy_o,
   output logic              mov_done_o,
   output logic              tick_overrun_o,
   output logic              aste_escape_o,
   input  logic              spawn_req_i,
   input  logic [DATA_W-1:0] spawn_data_i,
   output logic              spawn_ack_o,
   output logic              spawn_full_o,
   output logic [ADDR_W-1:0] spawn_slot_o,
   input  logic              rd_req_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic              rd_ack_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic [DATA_W-1:0] mem_q_i
);

   localparam logic [DATA_W-1:0] EMPTY     = DATA_W'(ASTE_EMPTY);
   localparam logic [ADDR_W-1:0] LAST_SLOT = '1;

   state_e              state_q;
   logic [ADDR_W-1:0]   idx_q;
   logic                tick_pend_q;
   logic                mov_done_q, tick_overrun_q;
   logic                spawn_ack_q, spawn_full_q;
   logic [ADDR_W-1:0]   spawn_slot_q;
   logic                rd_ack_q;
   logic [DATA_W-1:0]   rd_data_q;

   logic [DATA_W-1:0]   step_entry;
   logic                step_escape;

   escalonador_aste_step #(
      .COORD_W (COORD_W)
   ) u_step (
      .entry_i  (mem_q_i),
      .entry_o  (step_entry),
      .escape_o (step_escape)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= StIdle;
         idx_q          <= '0;
         tick_pend_q    <= 1'b0;
         mov_done_q     <= 1'b0;
         tick_overrun_q <= 1'b0;
         spawn_ack_q    <= 1'b0;
         spawn_full_q   <= 1'b0;
         spawn_slot_q   <= '0;
         rd_ack_q       <= 1'b0;
         rd_data_q      <= '0;
      end else begin
         mov_done_q     <= 1'b0;
         tick_overrun_q <= 1'b0;
         spawn_ack_q    <= 1'b0;
         rd_ack_q       <= 1'b0;

         if (tick_i) begin
            tick_pend_q <= 1'b1;
            if (tick_pend_q) tick_overrun_q <= 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               // A tick arriving in IDLE is accepted at once; clearing the
               // pending flag here overrides the set above.
               if (tick_i || tick_pend_q) begin
                  state_q     <= StMvAddr;
                  idx_q       <= '0;
                  tick_pend_q <= 1'b0;
               end else if (spawn_req_i && !spawn_ack_q) begin
                  // spawn_ack_q blocks re-acceptance while the requester drops.
                  if (spawn_data_i == EMPTY) begin
                     spawn_ack_q  <= 1'b1;
                     spawn_full_q <= 1'b1;
                     spawn_slot_q <= '0;
                  end else begin
                     state_q <= StSpAddr;
                     idx_q   <= '0;
                  end
               end else if (rd_req_i) begin
                  state_q <= StRdAddr;
                  idx_q   <= rd_addr_i;
               end
            end
            StMvAddr: state_q <= StMvUpd;
            StMvUpd: begin
               if (idx_q == LAST_SLOT) begin
                  state_q    <= StIdle;
                  mov_done_q <= 1'b1;
               end else begin
                  idx_q   <= idx_q + ADDR_W'(1);
                  state_q <= StMvAddr;
               end
            end
            StSpAddr: state_q <= StSpChk;
            StSpChk: begin
               if (mem_q_i == EMPTY) begin
                  state_q      <= StIdle;
                  spawn_ack_q  <= 1'b1;
                  spawn_full_q <= 1'b0;
                  spawn_slot_q <= idx_q;
               end else if (idx_q == LAST_SLOT) begin
                  state_q      <= StIdle;
                  spawn_ack_q  <= 1'b1;
                  spawn_full_q <= 1'b1;
                  spawn_slot_q <= '0;
               end else begin
                  idx_q   <= idx_q + ADDR_W'(1);
                  state_q <= StSpAddr;
               end
            end
            StRdAddr: state_q <= StRdCap;
            StRdCap: begin
               rd_data_q <= mem_q_i;
               rd_ack_q  <= 1'b1;
               state_q   <= StRdAck;
            end
            StRdAck: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Writes depend on the data read back this very cycle, so the memory
   // write port is decoded from the current state rather than registered.
   always_comb begin
      mem_we_o      = 1'b0;
      mem_data_o    = '0;
      aste_escape_o = 1'b0;
      unique case (state_q)
         StMvUpd: begin
            if (mem_q_i != EMPTY) begin
               mem_we_o      = 1'b1;
               mem_data_o    = step_entry;
               aste_escape_o = step_escape;
            end
         end
         StSpChk: begin
            if (mem_q_i == EMPTY) begin
               mem_we_o   = 1'b1;
               mem_data_o = spawn_data_i;
            end
         end
         default: ;
      endcase
   end

   assign mem_addr_o     = idx_q;
   assign mov_busy_o     = (state_q == StMvAddr) || (state_q == StMvUpd);
   assign mov_done_o     = mov_done_q;
   assign tick_overrun_o = tick_overrun_q;
   assign spawn_ack_o    = spawn_ack_q;
   assign spawn_full_o   = spawn_full_q;
   assign spawn_slot_o   = spawn_slot_q;
   assign rd_ack_o       = rd_ack_q;
   assign rd_data_o      = rd_data_q;

endmodule

// File: tb/tb_escalonador_aste.sv
// Scoreboard bench for escalonador_aste with a behavioural single-port memory.
module tb_escalonador_aste;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick, spawn_req, rd_req;
   logic [9:0] spawn_data;
   logic [3:0] rd_addr;
   logic       mov_busy, mov_done, tick_overrun, aste_escape;
   logic       spawn_ack, spawn_full, rd_ack, mem_we;
   logic [3:0] spawn_slot, mem_addr;
   logic [9:0] rd_data, mem_data, mem_q;

   always #5 clk = ~clk;

   escalonador_aste dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .tick_i         (tick),
      .mov_busy_o     (mov_busy),
      .mov_done_o     (mov_done),
      .tick_overrun_o (tick_overrun),
      .aste_escape_o  (aste_escape),
      .spawn_req_i    (spawn_req),
      .spawn_data_i   (spawn_data),
      .spawn_ack_o    (spawn_ack),
      .spawn_full_o   (spawn_full),
      .spawn_slot_o   (spawn_slot),
      .rd_req_i       (rd_req),
      .rd_addr_i      (rd_addr),
      .rd_ack_o       (rd_ack),
      .rd_data_o      (rd_data),
      .mem_we_o       (mem_we),
      .mem_addr_o     (mem_addr),
      .mem_data_o     (mem_data),
      .mem_q_i        (mem_q)
   );

   // Memory model: registered address, q valid the cycle after the address.
   logic [9:0] mem [16];
   logic [3:0] mem_addr_q;
   logic       pre_we, pre_clr;
   logic [3:0] pre_addr;
   logic [9:0] pre_data;

   always @(posedge clk) begin
      if (pre_clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (pre_we) begin
         mem[pre_addr] <= pre_data;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_data;
      end
      mem_addr_q <= mem_addr;
   end
   assign mem_q = mem[mem_addr_q];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic full; logic [3:0] slot; int cyc;} sp_exp_t;
   typedef struct {logic [9:0] data; int cyc;} rd_exp_t;

   sp_exp_t q_sp[$];
   rd_exp_t q_rd[$];
   int      q_done[$];
   sp_exp_t sp_e;
   rd_exp_t rd_e;
   int      done_e;

   int n_chk = 0;
   int n_pass = 0;
   int we_cnt, esc_cnt, ovr_cnt;
   int c0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
   endtask

   // Advance n cycles; requesters drop their level request on seeing the ack.
   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         if (spawn_ack) spawn_req = 1'b0;
         if (rd_ack) rd_req = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_mem(input logic [3:0] a, input logic [9:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      @(posedge clk);
      #1;
      pre_we = 1'b0;
   endtask

   task automatic clr_mem();
      pre_clr = 1'b1;
      @(posedge clk);
      #1;
      pre_clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; tick = 1'b0; spawn_req = 1'b0; rd_req = 1'b0;
      spawn_data = '0; rd_addr = '0;
      pre_we = 1'b0; pre_clr = 1'b0; pre_addr = '0; pre_data = '0;
      we_cnt = 0; esc_cnt = 0; ovr_cnt = 0;
      fork
         begin : monitor
            forever begin
               @(negedge clk);
               if (rst_n) begin
                  if (mem_we) we_cnt++;
                  if (aste_escape) esc_cnt++;
                  if (tick_overrun) ovr_cnt++;
                  if (mov_done) begin
                     chk("mov_done expected", 32'(q_done.size() != 0), 32'(1));
                     if (q_done.size() != 0) begin
                        done_e = q_done.pop_front();
                        chk("mov_done cycle", 32'(cyc), 32'(done_e));
                     end
                  end
                  if (spawn_ack) begin
                     chk("spawn_ack expected", 32'(q_sp.size() != 0), 32'(1));
                     if (q_sp.size() != 0) begin
                        sp_e = q_sp.pop_front();
                        chk("spawn_full", 32'(spawn_full), 32'(sp_e.full));
                        if (!sp_e.full) chk("spawn_slot", 32'(spawn_slot), 32'(sp_e.slot));
                        chk("spawn_ack cycle", 32'(cyc), 32'(sp_e.cyc));
                     end
                  end
                  if (rd_ack) begin
                     chk("rd_ack expected", 32'(q_rd.size() != 0), 32'(1));
                     if (q_rd.size() != 0) begin
                        rd_e = q_rd.pop_front();
                        chk("rd_data", 32'(rd_data), 32'(rd_e.data));
                        chk("rd_ack cycle", 32'(cyc), 32'(rd_e.cyc));
                     end
                  end
               end
            end
         end
         begin : stimulus
            @(posedge clk);
            @(posedge clk);
            #1;
            // Reset state.
            chk("reset mov_busy", 32'(mov_busy), 32'(0));
            chk("reset mov_done", 32'(mov_done), 32'(0));
            chk("reset mem_we", 32'(mem_we), 32'(0));
            chk("reset spawn_ack", 32'(spawn_ack), 32'(0));
            chk("reset rd_ack", 32'(rd_ack), 32'(0));
            chk("reset rd_data", 32'(rd_data), 32'(0));
            chk("reset tick_overrun", 32'(tick_overrun), 32'(0));
            rst_n = 1'b1;
            run(1);

            // Move pass: one slot moves in y, one in x.
            clr_mem();
            set_mem(4'd0, {4'd7, 4'd14, 2'b11});
            set_mem(4'd1, {4'd0, 4'd7, 2'b00});
            we_cnt = 0; esc_cnt = 0;
            tick = 1'b1;
            q_done.push_back(cyc + 33);
            run(1);
            tick = 1'b0;
            chk("mov_busy during pass", 32'(mov_busy), 32'(1));
            run(40);
            chk("move slot0", 32'(mem[0]), 32'({4'd7, 4'd13, 2'b11}));
            chk("move slot1", 32'(mem[1]), 32'({4'd1, 4'd7, 2'b00}));
            chk("move write count", 32'(we_cnt), 32'(2));
            chk("move no escape", 32'(esc_cnt), 32'(0));

            // Leaving the field at x = 15 heading +x.
            clr_mem();
            set_mem(4'd0, {4'd15, 4'd7, 2'b00});
            we_cnt = 0; esc_cnt = 0;
            tick = 1'b1;
            q_done.push_back(cyc + 33);
            run(1);
            tick = 1'b0;
            run(40);
`ifdef ASTE_WRAP_EN
            chk("edge slot0 wrapped", 32'(mem[0]), 32'({4'd0, 4'd7, 2'b00}));
            chk("edge escape count", 32'(esc_cnt), 32'(0));
`else
            chk("edge slot0 despawned", 32'(mem[0]), 32'(0));
            chk("edge escape count", 32'(esc_cnt), 32'(1));
`endif
            chk("edge write count", 32'(we_cnt), 32'(1));

            // Reset during MV_UPD of slot 1; no mov_done may follow.
            clr_mem();
            set_mem(4'd0, {4'd3, 4'd3, 2'b10});
            set_mem(4'd1, {4'd5, 4'd5, 2'b01});
            tick = 1'b1;
            run(1);
            tick = 1'b0;
            run(3);
            chk("mem_we before reset", 32'(mem_we), 32'(1));
            rst_n = 1'b0;
            #1;
            chk("mid-reset mem_we", 32'(mem_we), 32'(0));
            chk("mid-reset mov_busy", 32'(mov_busy), 32'(0));
            chk("mid-reset mem_data", 32'(mem_data), 32'(0));
            chk("mid-reset aste_escape", 32'(aste_escape), 32'(0));
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            run(40);
            chk("partial pass slot0 moved", 32'(mem[0]), 32'({4'd3, 4'd4, 2'b10}));
            chk("partial pass slot1 kept", 32'(mem[1]), 32'({4'd5, 4'd5, 2'b01}));

            // Spawn into first free slot, then into a full table, then zero data.
            clr_mem();
            set_mem(4'd0, 10'h001);
            set_mem(4'd1, 10'h3FF);
            set_mem(4'd2, 10'h155);
            for (int i = 4; i < 16; i++) set_mem(4'(i), 10'(10'h100 + i));
            we_cnt = 0;
            spawn_data = 10'b0111_1110_11;
            spawn_req  = 1'b1;
            q_sp.push_back('{1'b0, 4'd3, cyc + 9});
            run(15);
            chk("spawn slot3 data", 32'(mem[3]), 32'(10'b0111_1110_11));
            chk("spawn write count", 32'(we_cnt), 32'(1));
            we_cnt = 0;
            spawn_req = 1'b1;
            q_sp.push_back('{1'b1, 4'd0, cyc + 33});
            run(40);
            chk("spawn full no write", 32'(we_cnt), 32'(0));
            spawn_data = '0;
            spawn_req  = 1'b1;
            q_sp.push_back('{1'b1, 4'd0, cyc + 1});
            run(5);
            chk("spawn zero no write", 32'(we_cnt), 32'(0));

            // Reads.
            set_mem(4'd1, 10'b0000_0000_10);
            rd_addr = 4'd1;
            rd_req  = 1'b1;
            q_rd.push_back('{10'b0000_0000_10, cyc + 3});
            run(6);
            rd_addr = 4'd3;
            rd_req  = 1'b1;
            q_rd.push_back('{10'b0111_1110_11, cyc + 3});
            run(6);

            // All three requests at once, plus two ticks during the first pass.
            clr_mem();
            set_mem(4'd0, {4'd7, 4'd7, 2'b00});
            ovr_cnt = 0;
            c0 = cyc;
            tick = 1'b1; spawn_req = 1'b1; spawn_data = 10'h2A5;
            rd_req = 1'b1; rd_addr = 4'd0;
            q_done.push_back(c0 + 33);
            q_done.push_back(c0 + 66);
            q_sp.push_back('{1'b0, 4'd1, c0 + 71});
            q_rd.push_back('{{4'd9, 4'd7, 2'b00}, c0 + 74});
            run(1);
            tick = 1'b0;
            run(9);
            tick = 1'b1;
            run(2);
            tick = 1'b0;
            run(80);
            chk("overrun count", 32'(ovr_cnt), 32'(1));
            chk("combined slot0 two passes", 32'(mem[0]), 32'({4'd9, 4'd7, 2'b00}));
            chk("combined spawn slot1", 32'(mem[1]), 32'(10'h2A5));

            chk("done queue drained", 32'(q_done.size()), 32'(0));
            chk("spawn queue drained", 32'(q_sp.size()), 32'(0));
            chk("read queue drained", 32'(q_rd.size()), 32'(0));
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
         end
      join_any
   end

endmodule
